// File: rtl/multi_alarm_clock_pkg.sv
// Shared types for the multi-alarm 24-hour clock: alarm FSM states,
// the BCD HH:MM record and the entry-validity check.
package multi_alarm_clock_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZED = 2'd2
    } alarm_state_t;

    typedef struct packed {
        logic [3:0] ms_hour;
        logic [3:0] ls_hour;
        logic [3:0] ms_minute;
        logic [3:0] ls_minute;
    } bcd_time_t;

    localparam int MAX_HOUR = 23;
    localparam int MAX_MIN  = 59;

    function automatic logic time_valid(input bcd_time_t t);
        int hh;
        int mm;
        hh = int'(t.ms_hour) * 10 + int'(t.ls_hour);
        mm = int'(t.ms_minute) * 10 + int'(t.ls_minute);
        return (t.ls_hour <= 4'd9) && (t.ls_minute <= 4'd9) &&
               (hh <= MAX_HOUR) && (mm <= MAX_MIN);
    endfunction

endpackage

// File: rtl/multi_alarm_clock_if.sv
// Keypad/button inputs and display/buzzer outputs of the alarm clock.
// master = debouncer/display side, slave = the clock itself.
interface multi_alarm_clock_if #(
    parameter int AW = 2
);
    import multi_alarm_clock_pkg::*;

    logic [3:0]    key;
    logic          key_valid;
    logic          time_button;
    logic          alarm_button;
    logic [AW-1:0] alarm_sel;
    logic          alarm_disable;
    logic          show_alarm;
    logic          fast_watch;
    logic          stop_alarm;
    logic          snooze;
    logic [3:0]    ms_hour;
    logic [3:0]    ls_hour;
    logic [3:0]    ms_minute;
    logic [3:0]    ls_minute;
    logic          alarm_sound;
    logic [AW-1:0] alarm_id;
    logic          entry_err;
    alarm_state_t  alarm_state;

    modport master (
        output key, key_valid, time_button, alarm_button, alarm_sel,
               alarm_disable, show_alarm, fast_watch, stop_alarm, snooze,
        input  ms_hour, ls_hour, ms_minute, ls_minute, alarm_sound,
               alarm_id, entry_err, alarm_state
    );

    modport slave (
        input  key, key_valid, time_button, alarm_button, alarm_sel,
               alarm_disable, show_alarm, fast_watch, stop_alarm, snooze,
        output ms_hour, ls_hour, ms_minute, ls_minute, alarm_sound,
               alarm_id, entry_err, alarm_state
    );

endinterface

// File: rtl/multi_alarm_clock_bcd_time_counter.sv
// Prescaler, seconds and BCD HH:MM counter with a load port.
// minute_tick marks the edge on which HH:MM advances (never on a load edge).
module bcd_time_counter
    import multi_alarm_clock_pkg::*;
#(
    parameter int CLKS_PER_SEC = 256
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      fast_watch,
    input  logic      load,
    input  bcd_time_t load_time,
    output bcd_time_t cur_time,
    output logic      minute_tick
);
    localparam int PW = $clog2(CLKS_PER_SEC);

    logic [PW-1:0] presc;
    logic [5:0]    sec;
    logic          sec_tick;
    bcd_time_t     next_time;

    assign sec_tick    = (presc == PW'(CLKS_PER_SEC - 1));
    assign minute_tick = sec_tick && (fast_watch || sec == 6'd59) && !load;

    always_comb begin
        next_time = cur_time;
        if (cur_time.ls_minute != 4'd9) begin
            next_time.ls_minute = cur_time.ls_minute + 4'd1;
        end else begin
            next_time.ls_minute = 4'd0;
            if (cur_time.ms_minute != 4'd5) begin
                next_time.ms_minute = cur_time.ms_minute + 4'd1;
            end else begin
                next_time.ms_minute = 4'd0;
                // 23 -> 00 must be caught before the generic ls_hour carry
                if (cur_time.ms_hour == 4'd2 && cur_time.ls_hour == 4'd3) begin
                    next_time.ms_hour = 4'd0;
                    next_time.ls_hour = 4'd0;
                end else if (cur_time.ls_hour == 4'd9) begin
                    next_time.ls_hour = 4'd0;
                    next_time.ms_hour = cur_time.ms_hour + 4'd1;
                end else begin
                    next_time.ls_hour = cur_time.ls_hour + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            presc    <= '0;
            sec      <= 6'd0;
            cur_time <= '0;
        end else if (load) begin
            presc    <= '0;
            sec      <= 6'd0;
            cur_time <= load_time;
        end else begin
            presc <= sec_tick ? '0 : presc + PW'(1);
            if (sec_tick) begin
                if (fast_watch || sec == 6'd59) sec <= 6'd0;
                else                            sec <= sec + 6'd1;
            end
            if (minute_tick) cur_time <= next_time;
        end
    end

endmodule

// File: rtl/multi_alarm_clock.sv
// 24-hour clock with NUM_ALARMS alarm slots, ring timeout and stop control.
// Define SNOOZE_EN to build the snooze path and the SNOOZED state.
module multi_alarm_clock
    import multi_alarm_clock_pkg::*;
#(
    parameter int NUM_ALARMS   = 4,
    parameter int CLKS_PER_SEC = 256,
    parameter int RING_MIN     = 1,
    parameter int SNOOZE_MIN   = 5
) (
    input logic                clk,
    input logic                reset_n,
    multi_alarm_clock_if.slave bus
);
    localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

    bcd_time_t               buffer;
    bcd_time_t               cur_time;
    bcd_time_t               shown;
    bcd_time_t               slot_time [NUM_ALARMS];
    logic [NUM_ALARMS-1:0]   slot_en;
    logic                    time_q, alarm_q, time_req, alarm_req;
    logic                    buf_ok, sel_ok, key_err, load_err;
    logic                    do_time_load, do_alarm_load;
    logic                    minute_tick, eval_r, entry_err_r;
    logic                    match_hit;
    logic [AW-1:0]           match_idx, alarm_id_r;
    logic [5:0]              ring_cnt;
    alarm_state_t            state, next_state;

    assign buf_ok        = time_valid(buffer);
    assign sel_ok        = (int'(bus.alarm_sel) < NUM_ALARMS);
    assign key_err       = bus.key_valid && (bus.key > 4'd9);
    // A simultaneous time press takes priority; the alarm press is dropped
    assign do_time_load  = time_req && buf_ok;
    assign do_alarm_load = alarm_req && !time_req && buf_ok && sel_ok;
    assign load_err      = (time_req && !buf_ok) ||
                           (alarm_req && !time_req && !(buf_ok && sel_ok));

    bcd_time_counter #(.CLKS_PER_SEC(CLKS_PER_SEC)) u_counter (
        .clk         (clk),
        .reset_n     (reset_n),
        .fast_watch  (bus.fast_watch),
        .load        (do_time_load),
        .load_time   (buffer),
        .cur_time    (cur_time),
        .minute_tick (minute_tick)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            time_q      <= 1'b0;
            alarm_q     <= 1'b0;
            time_req    <= 1'b0;
            alarm_req   <= 1'b0;
            eval_r      <= 1'b0;
            entry_err_r <= 1'b0;
            buffer      <= '0;
            slot_en     <= '0;
            for (int i = 0; i < NUM_ALARMS; i++) slot_time[i] <= '0;
        end else begin
            time_q      <= bus.time_button;
            alarm_q     <= bus.alarm_button;
            time_req    <= bus.time_button && !time_q;
            alarm_req   <= bus.alarm_button && !alarm_q;
            eval_r      <= minute_tick || do_time_load;
            entry_err_r <= key_err || load_err;
            if (bus.key_valid && bus.key <= 4'd9)
                buffer <= {buffer.ls_hour, buffer.ms_minute, buffer.ls_minute, bus.key};
            if (do_alarm_load) begin
                slot_time[bus.alarm_sel] <= buffer;
                slot_en[bus.alarm_sel]   <= 1'b1;
            end else if (bus.alarm_disable && sel_ok) begin
                slot_en[bus.alarm_sel]   <= 1'b0;
            end
        end
    end

    // Descending scan so the lowest-index matching slot is the one kept
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (slot_en[i] && slot_time[i] == cur_time) begin
                match_hit = 1'b1;
                match_idx = AW'(i);
            end
        end
    end

`ifdef SNOOZE_EN
    logic [5:0] snooze_cnt;
`else
    logic unused_snooze;
    assign unused_snooze = bus.snooze ^ (SNOOZE_MIN == 0);
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (eval_r && match_hit) next_state = RINGING;
            RINGING: begin
                if (bus.stop_alarm || ring_cnt == 6'd0) next_state = IDLE;
`ifdef SNOOZE_EN
                else if (bus.snooze)                    next_state = SNOOZED;
`endif
            end
`ifdef SNOOZE_EN
            SNOOZED: begin
                if (bus.stop_alarm)            next_state = IDLE;
                else if (snooze_cnt == 6'd0)   next_state = RINGING;
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.alarm_sound = (state == RINGING);
        bus.alarm_state = state;
        bus.alarm_id    = alarm_id_r;
        bus.entry_err   = entry_err_r;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ring_cnt   <= 6'd0;
            alarm_id_r <= '0;
`ifdef SNOOZE_EN
            snooze_cnt <= 6'd0;
`endif
        end else begin
            if (state == IDLE && next_state == RINGING) alarm_id_r <= match_idx;
            if (state != RINGING && next_state == RINGING)
                ring_cnt <= 6'(RING_MIN);
            else if (state == RINGING && minute_tick && ring_cnt != 6'd0)
                ring_cnt <= ring_cnt - 6'd1;
`ifdef SNOOZE_EN
            if (state == RINGING && next_state == SNOOZED)
                snooze_cnt <= 6'(SNOOZE_MIN);
            else if (state == SNOOZED && minute_tick && snooze_cnt != 6'd0)
                snooze_cnt <= snooze_cnt - 6'd1;
`endif
        end
    end

    always_comb begin
        shown = cur_time;
        if (bus.show_alarm && sel_ok) shown = slot_time[bus.alarm_sel];
    end

    assign bus.ms_hour   = shown.ms_hour;
    assign bus.ls_hour   = shown.ls_hour;
    assign bus.ms_minute = shown.ms_minute;
    assign bus.ls_minute = shown.ls_minute;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Directed bench for multi_alarm_clock: a table of time-load vectors plus
// hand-written sequences for ringing, stop/snooze, key errors and reset.
module tb_multi_alarm_clock;
    import multi_alarm_clock_pkg::*;

    localparam int AW = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    multi_alarm_clock_if #(.AW(AW)) bus ();

    multi_alarm_clock #(
        .NUM_ALARMS   (4),
        .CLKS_PER_SEC (4),
        .RING_MIN     (1),
        .SNOOZE_MIN   (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int check_cnt = 0;
    int pass_cnt  = 0;

    typedef struct {
        logic [15:0] digits;
        logic        exp_err;
        logic [15:0] exp_disp;
    } vec_t;

    vec_t vecs [7];

    function automatic logic [15:0] disp();
        return {bus.ms_hour, bus.ls_hour, bus.ms_minute, bus.ls_minute};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_key(input logic [3:0] d);
        bus.key       = d;
        bus.key_valid = 1'b1;
        step(1);
        bus.key_valid = 1'b0;
    endtask

    task automatic enter(input logic [15:0] v);
        for (int i = 3; i >= 0; i--) press_key(v[i*4 +: 4]);
    endtask

    task automatic pulse_time();
        bus.time_button = 1'b1;
        step(1);
        bus.time_button = 1'b0;
        step(1);
    endtask

    task automatic pulse_alarm();
        bus.alarm_button = 1'b1;
        step(1);
        bus.alarm_button = 1'b0;
        step(1);
    endtask

    task automatic load_time(input logic [15:0] v);
        enter(v);
        pulse_time();
    endtask

    // Load 12:34 and run fast; the 12:35 match rings 5 clocks after the load
    task automatic ring_1234();
        load_time(16'h1234);
        bus.fast_watch = 1'b1;
        step(5);
    endtask

    initial begin
        logic rang;
        bus.key = 4'd0;          bus.key_valid = 1'b0;
        bus.time_button = 1'b0;  bus.alarm_button = 1'b0;
        bus.alarm_sel = '0;      bus.alarm_disable = 1'b0;
        bus.show_alarm = 1'b0;   bus.fast_watch = 1'b0;
        bus.stop_alarm = 1'b0;   bus.snooze = 1'b0;

        vecs[0] = '{16'h1234, 1'b0, 16'h1234};
        vecs[1] = '{16'h2500, 1'b1, 16'h1234};
        vecs[2] = '{16'h2359, 1'b0, 16'h2359};
        vecs[3] = '{16'h0960, 1'b1, 16'h2359};
        vecs[4] = '{16'h1959, 1'b0, 16'h1959};
        vecs[5] = '{16'h0000, 1'b0, 16'h0000};
        vecs[6] = '{16'h2400, 1'b1, 16'h0000};

        // Reset state
        step(2);
        check("reset disp", disp(), 16'h0000);
        check("reset sound", bus.alarm_sound, 1'b0);
        check("reset id", bus.alarm_id, 2'd0);
        check("reset err", bus.entry_err, 1'b0);
        check("reset state", bus.alarm_state, IDLE);
        reset_n = 1'b1;

        // Table of time loads, valid and invalid
        for (int i = 0; i < 7; i++) begin
            load_time(vecs[i].digits);
            check($sformatf("vec%0d disp", i), disp(), vecs[i].exp_disp);
            check($sformatf("vec%0d err", i), bus.entry_err, vecs[i].exp_err);
            step(1);
            check($sformatf("vec%0d err clear", i), bus.entry_err, 1'b0);
        end

        // Seconds cleared by load: minute advances exactly 240 clocks later
        load_time(16'h1234);
        check("load 1234", disp(), 16'h1234);
        step(239);
        check("before minute", disp(), 16'h1234);
        step(1);
        check("after minute", disp(), 16'h1235);

        // Midnight wrap in fast mode
        load_time(16'h2359);
        bus.fast_watch = 1'b1;
        step(3);
        check("pre wrap", disp(), 16'h2359);
        step(1);
        check("wrap 0000", disp(), 16'h0000);
        bus.fast_watch = 1'b0;

        // Two slots at 12:35; lowest index wins
        enter(16'h1235);
        bus.alarm_sel = 2'd2;
        pulse_alarm();
        bus.alarm_sel = 2'd0;
        pulse_alarm();
        bus.show_alarm = 1'b1;
        bus.alarm_sel = 2'd2;
        #1;
        check("slot2 disp", disp(), 16'h1235);
        bus.alarm_sel = 2'd1;
        #1;
        check("slot1 disp", disp(), 16'h0000);
        bus.show_alarm = 1'b0;
        bus.alarm_sel = 2'd0;

        load_time(16'h1234);
        bus.fast_watch = 1'b1;
        step(4);
        check("match minute", disp(), 16'h1235);
        check("sound latency", bus.alarm_sound, 1'b0);
        step(1);
        check("ring sound", bus.alarm_sound, 1'b1);
        check("ring id", bus.alarm_id, 2'd0);
        check("ring state", bus.alarm_state, RINGING);
        step(3);
        check("still ringing", bus.alarm_sound, 1'b1);
        step(1);
        check("ring timeout", bus.alarm_sound, 1'b0);
        bus.fast_watch = 1'b0;

        // Disable slot 0 so slot 2 rings; then exercise snooze
        bus.alarm_sel = 2'd0;
        bus.alarm_disable = 1'b1;
        step(1);
        bus.alarm_disable = 1'b0;
        ring_1234();
        check("slot2 ring", bus.alarm_sound, 1'b1);
        check("slot2 id", bus.alarm_id, 2'd2);
        bus.snooze = 1'b1;
        step(1);
        bus.snooze = 1'b0;
`ifdef SNOOZE_EN
        check("snooze off", bus.alarm_sound, 1'b0);
        check("snooze state", bus.alarm_state, SNOOZED);
        rang = 1'b0;
        for (int i = 0; i < 12 && !rang; i++) begin
            step(1);
            if (bus.alarm_sound) rang = 1'b1;
        end
        check("snooze re-ring", rang, 1'b1);
        check("snooze id", bus.alarm_id, 2'd2);
`else
        rang = 1'b0;
        check("snooze ignored", bus.alarm_sound, 1'b1);
`endif
        bus.stop_alarm = 1'b1;
        step(1);
        bus.stop_alarm = 1'b0;
        check("stop", bus.alarm_sound, 1'b0);
        bus.fast_watch = 1'b0;

        // Stop and snooze together: stop wins
        ring_1234();
        check("ring again", bus.alarm_sound, 1'b1);
        bus.stop_alarm = 1'b1;
        bus.snooze = 1'b1;
        step(1);
        bus.stop_alarm = 1'b0;
        bus.snooze = 1'b0;
        check("stop+snooze sound", bus.alarm_sound, 1'b0);
        check("stop+snooze state", bus.alarm_state, IDLE);
        step(4);
        check("stays idle", bus.alarm_state, IDLE);
        bus.fast_watch = 1'b0;

        // Illegal key is rejected and leaves the buffer (1234) intact
        press_key(4'hA);
        check("bad key err", bus.entry_err, 1'b1);
        step(1);
        check("bad key clear", bus.entry_err, 1'b0);
        pulse_time();
        check("buffer kept", disp(), 16'h1234);
        check("buffer load ok", bus.entry_err, 1'b0);

        // Both buttons together: time loads, alarm dropped
        enter(16'h0745);
        bus.alarm_sel = 2'd1;
        bus.time_button = 1'b1;
        bus.alarm_button = 1'b1;
        step(1);
        bus.time_button = 1'b0;
        bus.alarm_button = 1'b0;
        step(1);
        check("both time", disp(), 16'h0745);
        bus.show_alarm = 1'b1;
        #1;
        check("both slot1", disp(), 16'h0000);
        bus.show_alarm = 1'b0;

        // Reset while ringing
        ring_1234();
        check("pre reset ring", bus.alarm_sound, 1'b1);
        reset_n = 1'b0;
        step(1);
        check("reset ring sound", bus.alarm_sound, 1'b0);
        check("reset ring disp", disp(), 16'h0000);
        check("reset ring id", bus.alarm_id, 2'd0);
        reset_n = 1'b1;
        bus.fast_watch = 1'b0;
        bus.show_alarm = 1'b1;
        bus.alarm_sel = 2'd2;
        #1;
        check("reset slot2", disp(), 16'h0000);
        bus.show_alarm = 1'b0;
        load_time(16'h2359);
        bus.fast_watch = 1'b1;
        step(6);
        check("disabled slots", bus.alarm_sound, 1'b0);
        check("midnight disp", disp(), 16'h0000);
        bus.fast_watch = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
